sprite_board_writer: RTL and testbench

Parametrised sprite compositor for the tile board RAM: on each `update` pulse it erases every sprite from its previous tile (restoring the saved underlying tile), then redraws all sprites at their new tiles, saving each new underlay. It generalises the single-sprite Pac-Man write path to `NUM_SPRITES` sprites (sprite 0 = Pac-Man, 1..N-1 = ghosts). It also reports pellet consumption and Pac/ghost collision. It sits between the movement blocks and a dedicated read/write port of the dual-port board RAM; the video path uses the other port.

---
 rtl/sprite_board_writer.sv | 195 +++++++++++++++++++
 tb/tb_sprite_board_writer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_board_writer.sv
`default_nettype none
// ============================================================================
// Module      : sprite_board_writer
// Description : Multi-sprite compositor for the tile board RAM. Each accepted
//               update erases every sprite from its previous tile (restoring
//               the saved underlay), then redraws all sprites at their new
//               tiles, saving each new underlay. Also reports pellets eaten
//               by Pac-Man (sprite 0) and Pac/ghost collision.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_board_writer #(
    parameter int NUM_SPRITES = 5,
    parameter int COLS        = 32,
    parameter int ROWS        = 24,
    parameter int ADDR_W      = 10,
    parameter int TYPE_W      = 4,
    parameter int BLANK_TYPE  = 0,
    parameter int PELLET_TYPE = 1,
    parameter int SPRITE_BASE = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          update,
    input  logic [NUM_SPRITES*ADDR_W-1:0] locs,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [TYPE_W-1:0]             ram_wdata,
    output logic                          ram_wren,
    input  logic [TYPE_W-1:0]             ram_rdata,
    output logic                          busy,
    output logic                          done,
    output logic                          pellet_eaten,
    output logic [15:0]                   pellet_count,
    output logic                          collision
);

    localparam int                IDX_W     = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_SPRITES - 1);
    localparam logic [ADDR_W:0]   NUM_TILES = (ADDR_W + 1)'(COLS * ROWS);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ERASE   = 3'd1;
    localparam logic [2:0] ST_DRAW_RD = 3'd2;
    localparam logic [2:0] ST_DRAW_WR = 3'd3;
    localparam logic [2:0] ST_FINISH  = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [ADDR_W-1:0]      new_loc_w   [NUM_SPRITES];
    logic [ADDR_W-1:0]      loc_q       [NUM_SPRITES];
    logic [ADDR_W-1:0]      prev_loc_q  [NUM_SPRITES];
    logic [TYPE_W-1:0]      underlay_q  [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] valid_q;
    logic [ADDR_W-1:0]      ram_addr_q, ram_addr_d;
    logic [TYPE_W-1:0]      ram_wdata_q, ram_wdata_d;
    logic                   ram_wren_q, ram_wren_d;
    logic [15:0]            pellet_count_q;
    logic                   collision_q, collision_d;
    logic                   pac_eats_w;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NUM_TILES;
    endfunction

    // Split the flat location bus into one tile address per sprite.
    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_unpack_locs
        assign new_loc_w[g] = locs[g*ADDR_W +: ADDR_W];
    end

    // State and sprite-index register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: erase ascending, then read/write pairs descending so that
    // stacked sprites unwind in the reverse order they were stacked.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (update) begin
                    state_d = ST_ERASE;
                    idx_d   = '0;
                end
            end
            ST_ERASE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DRAW_RD;
                    idx_d   = LAST_IDX;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DRAW_RD: state_d = ST_DRAW_WR;
            ST_DRAW_WR: begin
                if (idx_q == '0) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_DRAW_RD;
                    idx_d   = idx_q - 1'b1;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // RAM command for the upcoming cycle, derived from the next state so the
    // registered outputs line up with the state they belong to.
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = '0;
        ram_wren_d  = 1'b0;
        case (state_d)
            ST_ERASE: begin
                ram_addr_d  = prev_loc_q[idx_d];
                ram_wdata_d = underlay_q[idx_d];
                ram_wren_d  = valid_q[idx_d];
            end
            ST_DRAW_RD: begin
                ram_addr_d = loc_q[idx_d];
            end
            ST_DRAW_WR: begin
                ram_addr_d  = loc_q[idx_d];
                ram_wdata_d = TYPE_W'(SPRITE_BASE) + TYPE_W'(idx_d);
                ram_wren_d  = in_range(loc_q[idx_d]);
            end
            default: ;
        endcase
    end

    // Pac-Man eats only a pellet it reads directly during its own draw.
    assign pac_eats_w = (state_q == ST_DRAW_WR) && (idx_q == '0) && in_range(loc_q[0])
                        && (ram_rdata == TYPE_W'(PELLET_TYPE));

    // Collision: any in-range ghost on Pac-Man's in-range tile.
    always_comb begin
        collision_d = 1'b0;
        for (int j = 1; j < NUM_SPRITES; j++) begin
            if (in_range(loc_q[0]) && in_range(loc_q[j]) && (loc_q[j] == loc_q[0]))
                collision_d = 1'b1;
        end
    end

    // Registered RAM port, valid bits, pellet counter and collision flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ram_addr_q     <= '0;
            ram_wdata_q    <= '0;
            ram_wren_q     <= 1'b0;
            valid_q        <= '0;
            pellet_count_q <= '0;
            collision_q    <= 1'b0;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wren_q  <= ram_wren_d;
            if (state_q == ST_DRAW_WR)
                valid_q[idx_q] <= in_range(loc_q[idx_q]);
            if (pac_eats_w && (pellet_count_q != 16'hFFFF))
                pellet_count_q <= pellet_count_q + 16'd1;
            if (state_q == ST_FINISH)
                collision_q <= collision_d;
        end
    end

    // Per-sprite data: latched locations, previous tiles and saved underlays.
    always_ff @(posedge clk) begin
        if ((state_q == ST_IDLE) && update) begin
            for (int i = 0; i < NUM_SPRITES; i++)
                loc_q[i] <= new_loc_w[i];
        end
        if (state_q == ST_DRAW_WR) begin
            prev_loc_q[idx_q] <= loc_q[idx_q];
            underlay_q[idx_q] <= pac_eats_w ? TYPE_W'(BLANK_TYPE) : ram_rdata;
        end
    end

    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = ram_wdata_q;
    assign ram_wren     = ram_wren_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_FINISH);
    assign pellet_eaten = pac_eats_w;
    assign pellet_count = pellet_count_q;
    assign collision    = collision_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_board_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_board_writer
// Description : Self-checking bench for sprite_board_writer with a board RAM
//               model and a scoreboard of expected writes and pellet pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_board_writer;

    localparam int N     = 5;
    localparam int AW    = 10;
    localparam int TW    = 4;
    localparam int TILES = 768;
    localparam logic [TW-1:0] PELLET = 4'd1;
    localparam logic [TW-1:0] BLANK  = 4'd0;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [TW-1:0] data;
    } wr_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            update = 1'b0;
    logic [N*AW-1:0] locs = '0;
    logic [AW-1:0]   ram_addr;
    logic [TW-1:0]   ram_wdata;
    logic            ram_wren;
    logic [TW-1:0]   ram_rdata = '0;
    logic            busy, done, pellet_eaten, collision;
    logic [15:0]     pellet_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [TW-1:0] mem   [1024];
    logic [TW-1:0] board [1024];
    logic [AW-1:0] m_prev  [N];
    logic [TW-1:0] m_under [N];
    bit            m_valid [N];
    int            m_pellets = 0;
    bit            m_coll = 1'b0;
    wr_t           wq[$];
    int            pq[$];
    wr_t           mon_w;
    int            mon_p;

    sprite_board_writer dut (
        .clk          (clk),
        .reset        (reset),
        .update       (update),
        .locs         (locs),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_wren     (ram_wren),
        .ram_rdata    (ram_rdata),
        .busy         (busy),
        .done         (done),
        .pellet_eaten (pellet_eaten),
        .pellet_count (pellet_count),
        .collision    (collision)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Board RAM: synchronous write, read data one cycle after the address.
    always @(posedge clk) begin
        if (ram_wren === 1'b1) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference behaviour of one pass; cut >= 0 means reset lands at that cycle.
    function automatic void model_pass(input logic [AW-1:0] l [N], input int start, input int cut);
        int lim;
        int c;
        logic [TW-1:0] u;
        lim = (cut < 0) ? 1000 : cut;
        for (int i = 0; i < N; i++) begin
            c = 1 + i;
            if (c <= lim && m_valid[i]) begin
                board[m_prev[i]] = m_under[i];
                wq.push_back('{start + c, m_prev[i], m_under[i]});
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            c = N + 2 + 2 * (N - 1 - i);
            if (c > lim) break;
            if (int'(l[i]) < TILES) begin
                u = board[l[i]];
                if (i == 0 && u == PELLET) begin
                    u = BLANK;
                    if (m_pellets < 65535) m_pellets++;
                    pq.push_back(start + c);
                end
                m_under[i] = u;
                board[l[i]] = TW'(3 + i);
                wq.push_back('{start + c, l[i], TW'(3 + i)});
                m_prev[i]  = l[i];
                m_valid[i] = 1'b1;
            end else begin
                m_valid[i] = 1'b0;
            end
        end
        if (cut >= 0) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
            m_pellets = 0;
            m_coll    = 1'b0;
        end else begin
            m_coll = 1'b0;
            for (int j = 1; j < N; j++)
                if (int'(l[0]) < TILES && int'(l[j]) < TILES && l[j] == l[0]) m_coll = 1'b1;
        end
    endfunction

    // Scoreboard: every RAM write and pellet pulse must match the next expectation.
    always @(negedge clk) begin
        if (ram_wren === 1'b1) begin
            if (wq.size() == 0) begin
                check_eq("wr_unexpected_qsize", wq.size(), 1);
            end else begin
                mon_w = wq.pop_front();
                check_eq("wr_cycle", cyc, mon_w.cyc);
                check_eq("wr_addr", 32'(ram_addr), 32'(mon_w.addr));
                check_eq("wr_data", 32'(ram_wdata), 32'(mon_w.data));
            end
        end
        if (pellet_eaten === 1'b1) begin
            if (pq.size() == 0) begin
                check_eq("pel_unexpected_qsize", pq.size(), 1);
            end else begin
                mon_p = pq.pop_front();
                check_eq("pel_cycle", cyc, mon_p);
            end
        end
    end

    task automatic run_pass(input logic [AW-1:0] l [N], input int glitch_at, input int rst_at);
        int start;
        int done_at;
        int exp_done;
        done_at  = -1;
        exp_done = (rst_at < 0) ? 3 * N + 1 : -1;
        @(posedge clk); #1;
        start = cyc;
        model_pass(l, start, rst_at);
        for (int i = 0; i < N; i++) locs[i*AW +: AW] = l[i];
        update = 1'b1;
        for (int k = 1; k <= 3 * N + 6; k++) begin
            @(posedge clk); #1;
            update = (k == glitch_at);
            if (k == glitch_at) locs = {N{10'd600}};
            if (rst_at >= 0 && k == rst_at)     reset = 1'b0;
            if (rst_at >= 0 && k == rst_at + 1) reset = 1'b1;
            @(negedge clk);
            if (done === 1'b1 && done_at < 0) done_at = k;
            if (k == 1) check_eq("busy_start", 32'(busy), 1);
            if (rst_at < 0 && k == 3 * N + 2) check_eq("busy_end", 32'(busy), 0);
            if (rst_at >= 0 && k == rst_at + 1) begin
                check_eq("rst_wren", 32'(ram_wren), 0);
                check_eq("rst_busy", 32'(busy), 0);
            end
        end
        check_eq("done_cycle", done_at, exp_done);
        check_eq("busy_idle", 32'(busy), 0);
        check_eq("pellet_count", 32'(pellet_count), m_pellets);
        check_eq("collision", 32'(collision), 32'(m_coll));
        check_eq("wr_left", wq.size(), 0);
        check_eq("pel_left", pq.size(), 0);
        wq.delete();
        pq.delete();
    endtask

    initial begin
        logic [AW-1:0] L [N];
        for (int i = 0; i < 1024; i++) begin
            mem[i]   = PELLET;
            board[i] = PELLET;
        end
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ram_addr", 32'(ram_addr), 0);
        check_eq("rst_ram_wdata", 32'(ram_wdata), 0);
        check_eq("rst_ram_wren", 32'(ram_wren), 0);
        check_eq("rst_busy0", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_pellet_eaten", 32'(pellet_eaten), 0);
        check_eq("rst_pellet_count", 32'(pellet_count), 0);
        check_eq("rst_collision", 32'(collision), 0);
        @(posedge clk); #1;
        reset = 1'b1;

        L = '{10'd495, 10'd100, 10'd101, 10'd102, 10'd103};
        run_pass(L, -1, -1);
        L = '{10'd496, 10'd100, 10'd101, 10'd102, 10'd103};
        run_pass(L, -1, -1);
        L = '{10'd496, 10'd496, 10'd101, 10'd102, 10'd103};
        run_pass(L, -1, -1);
        check_eq("collision_on", 32'(collision), 1);
        L = '{10'd496, 10'd200, 10'd200, 10'd102, 10'd103};
        run_pass(L, -1, -1);
        check_eq("collision_off", 32'(collision), 0);
        L = '{10'd496, 10'd300, 10'd301, 10'd102, 10'd103};
        run_pass(L, -1, -1);
        check_eq("tile200_restored", 32'(mem[200]), 32'(PELLET));
        L = '{10'd496, 10'd300, 10'd301, 10'd102, 10'd768};
        run_pass(L, 5, -1);
        L = '{10'd497, 10'd300, 10'd301, 10'd102, 10'd500};
        run_pass(L, -1, -1);
        L = '{10'd498, 10'd300, 10'd301, 10'd110, 10'd510};
        run_pass(L, -1, 8);
        L = '{10'd499, 10'd310, 10'd311, 10'd110, 10'd510};
        run_pass(L, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
